task_handshake_monitor: RTL and testbench

- Parametrised, clocked successor to the static top-to-interface binding used for the formal environment.
- Watches N engine channels (packet builders plus parser) on their start/busy/irq register signals, with one protocol state machine per channel.
- Measures task latency and flags protocol violations.
- Emits one completion record per task through a FIFO with a valid/ready handshake, for scoreboards and formal covers.

---
 rtl/task_handshake_monitor.sv | 221 ++++++++++++++++++++++
 tb/tb_task_handshake_monitor.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/task_handshake_monitor.sv
// Watches start/busy/irq on NUM_CH engine channels, times each task and queues one
// {chan, cycles, err} completion record per task behind a valid/ready FIFO.
module task_handshake_monitor #(
    parameter int NUM_CH     = 3,
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int START_TO   = 8,
    parameter int IRQ_WIN    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CH-1:0]             ch_start,
    input  logic [NUM_CH-1:0]             ch_busy,
    input  logic [NUM_CH-1:0]             ch_irq,
    output logic                          rec_valid,
    input  logic                          rec_ready,
    output logic [2:0]                    rec_chan,
    output logic [CNT_W-1:0]              rec_cycles,
    output logic [1:0]                    rec_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [NUM_CH-1:0]             ch_active,
    output logic [NUM_CH-1:0]             proto_err,
    output logic [7:0]                    drop_cnt
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int TAIL_W = $clog2(IRQ_WIN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [PTR_W:0]   LVL_FULL = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   LVL_ONE  = (PTR_W + 1)'(1);
    localparam logic [1:0] E_OK = 2'd0, E_START_TO = 2'd1, E_IRQ_MISS = 2'd2;

    generate
        if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
            $error("task_handshake_monitor: NUM_CH must be 1..8");
        end
        if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("task_handshake_monitor: FIFO_DEPTH must be a power of two in 2..16");
        end
        if (START_TO < 1 || IRQ_WIN < 1) begin : g_bad_timeout
            $error("task_handshake_monitor: START_TO and IRQ_WIN must be at least 1");
        end
    endgenerate

    typedef enum logic [2:0] {S_IDLE, S_ARMED, S_RUN, S_TAIL, S_HOLD} state_t;

    typedef struct packed {
        logic [2:0]       chan;
        logic [CNT_W-1:0] cycles;
        logic [1:0]       err;
    } rec_t;

    state_t           r_state [NUM_CH];
    state_t           w_state_nxt [NUM_CH];
    logic [CNT_W-1:0] r_cnt [NUM_CH];
    logic [CNT_W-1:0] w_cnt_nxt [NUM_CH];
    logic [TAIL_W-1:0] r_tail [NUM_CH];
    logic [TAIL_W-1:0] w_tail_nxt [NUM_CH];
    logic [1:0]       r_err [NUM_CH];
    logic [1:0]       w_err_nxt [NUM_CH];
    logic [NUM_CH-1:0] r_busy_q, r_proto_err, w_viol, w_drop, w_gnt;
    logic [7:0]       r_drop_cnt, w_drop_cnt_nxt;
    logic [3:0]       w_drop_num;
    logic [8:0]       w_drop_sum;
    logic [2:0]       r_rr_ptr, w_rr_ptr_nxt;
    logic             w_push, w_pop, w_full;
    rec_t             w_push_rec, w_head;
    rec_t             r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [PTR_W:0]   r_level;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // The counter holds the latency of the current cycle, so it is loaded with 1 on
    // the edge that samples start and freezes on entry to HOLD as the record value.
    always_comb begin
        w_drop_num = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            // NOTE: every always_comb output gets a default first, so no path can infer a latch.
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = r_cnt[i];
            w_tail_nxt[i]  = r_tail[i];
            w_err_nxt[i]   = r_err[i];
            w_viol[i]      = 1'b0;
            w_drop[i]      = 1'b0;
            case (r_state[i])
                S_IDLE: begin
                    w_viol[i] = (ch_busy[i] & ~r_busy_q[i]) | ch_irq[i];
                    if (ch_start[i]) begin
                        w_state_nxt[i] = S_ARMED;
                        w_cnt_nxt[i]   = CNT_W'(1);
                        w_err_nxt[i]   = E_OK;
                    end
                end
                S_ARMED: begin
                    w_viol[i] = ch_start[i] | ch_irq[i];
                    if (ch_busy[i]) begin
                        w_state_nxt[i] = S_RUN;
                        w_cnt_nxt[i]   = sat_inc(r_cnt[i]);
                    end else if (r_cnt[i] == CNT_W'(START_TO)) begin
                        w_state_nxt[i] = S_HOLD;
                        w_err_nxt[i]   = E_START_TO;
                    end else begin
                        w_cnt_nxt[i] = sat_inc(r_cnt[i]);
                    end
                end
                S_RUN: begin
                    w_viol[i] = ch_start[i];
                    if (ch_irq[i]) begin
                        w_state_nxt[i] = S_HOLD;
                        w_err_nxt[i]   = E_OK;
                    end else begin
                        w_cnt_nxt[i] = sat_inc(r_cnt[i]);
                        if (!ch_busy[i]) begin
                            w_state_nxt[i] = S_TAIL;
                            w_tail_nxt[i]  = TAIL_W'(1);
                        end
                    end
                end
                S_TAIL: begin
                    w_viol[i] = ch_start[i];
                    if (ch_irq[i]) begin
                        w_state_nxt[i] = S_HOLD;
                        w_err_nxt[i]   = E_OK;
                    end else if (r_tail[i] == TAIL_W'(IRQ_WIN)) begin
                        w_state_nxt[i] = S_HOLD;
                        w_err_nxt[i]   = E_IRQ_MISS;
                    end else begin
                        w_tail_nxt[i] = r_tail[i] + TAIL_W'(1);
                        w_cnt_nxt[i]  = sat_inc(r_cnt[i]);
                    end
                end
                S_HOLD: begin
                    w_drop[i] = ch_start[i];
                    if (w_gnt[i]) w_state_nxt[i] = S_IDLE;
                end
                default: w_state_nxt[i] = S_IDLE;
            endcase
            if (w_drop[i]) w_drop_num = w_drop_num + 4'd1;
        end
        w_drop_sum     = {1'b0, r_drop_cnt} + 9'(w_drop_num);
        w_drop_cnt_nxt = w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
    end

    // Round-robin grant over HOLD channels, starting the search at r_rr_ptr.
    always_comb begin
        w_gnt        = '0;
        w_push       = 1'b0;
        w_push_rec   = '0;
        w_rr_ptr_nxt = r_rr_ptr;
        if (!w_full || w_pop) begin
            for (int k = 0; k < NUM_CH; k++) begin
                for (int j = 0; j < NUM_CH; j++) begin
                    if (!w_push && r_state[j] == S_HOLD && ((int'(r_rr_ptr) + k) % NUM_CH) == j) begin
                        w_push       = 1'b1;
                        w_gnt[j]     = 1'b1;
                        w_push_rec   = '{chan: 3'(j), cycles: r_cnt[j], err: r_err[j]};
                        w_rr_ptr_nxt = (j == NUM_CH - 1) ? 3'd0 : 3'(j + 1);
                    end
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i] <= S_IDLE;
                r_cnt[i]   <= '0;
                r_tail[i]  <= '0;
                r_err[i]   <= E_OK;
            end
            r_busy_q    <= '0;
            r_proto_err <= '0;
            r_drop_cnt  <= '0;
            r_rr_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
                r_tail[i]  <= w_tail_nxt[i];
                r_err[i]   <= w_err_nxt[i];
            end
            r_busy_q    <= ch_busy;
            r_proto_err <= r_proto_err | w_viol;
            r_drop_cnt  <= w_drop_cnt_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)      r_level <= r_level + LVL_ONE;
            else if (w_pop && !w_push) r_level <= r_level - LVL_ONE;
        end
    end

    // NOTE: record storage is not reset; the pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_push_rec;
    end

    assign w_full     = (r_level == LVL_FULL);
    assign rec_valid  = (r_level != '0);
    assign w_pop      = rec_valid & rec_ready;
    assign w_head     = r_mem[r_rd_ptr];
    assign rec_chan   = rec_valid ? w_head.chan   : 3'd0;
    assign rec_cycles = rec_valid ? w_head.cycles : '0;
    assign rec_err    = rec_valid ? w_head.err    : E_OK;
    assign fifo_level = r_level;
    assign proto_err  = r_proto_err;
    assign drop_cnt   = r_drop_cnt;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) ch_active[i] = (r_state[i] != S_IDLE);
    end

endmodule

// File: tb/tb_task_handshake_monitor.sv
// Directed scenarios plus random start/busy/irq traffic, compared every cycle against a
// timestamp-based model of the channel protocol and a queue model of the record FIFO.
module tb_task_handshake_monitor;
    localparam int NUM_CH = 3, CNT_W = 16, FIFO_DEPTH = 4, START_TO = 8, IRQ_WIN = 4;
    localparam int LVL_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;
    logic [NUM_CH-1:0] ch_start, ch_busy, ch_irq;
    logic rec_valid, rec_ready;
    logic [2:0] rec_chan;
    logic [CNT_W-1:0] rec_cycles;
    logic [1:0] rec_err;
    logic [LVL_W-1:0] fifo_level;
    logic [NUM_CH-1:0] ch_active, proto_err;
    logic [7:0] drop_cnt;

    task_handshake_monitor #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .FIFO_DEPTH(FIFO_DEPTH),
        .START_TO(START_TO), .IRQ_WIN(IRQ_WIN)
    ) dut (
        .clk(clk), .reset(reset),
        .ch_start(ch_start), .ch_busy(ch_busy), .ch_irq(ch_irq),
        .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_chan(rec_chan), .rec_cycles(rec_cycles), .rec_err(rec_err),
        .fifo_level(fifo_level), .ch_active(ch_active),
        .proto_err(proto_err), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: each channel remembers what it waits for and the cycle numbers
    // of start and busy falling; latencies are differences of cycle numbers.
    typedef struct { int chan; int cycles; int err; } rec_t;
    localparam int PH_IDLE = 0, PH_WAIT_BUSY = 1, PH_BUSY = 2, PH_WAIT_IRQ = 3, PH_PENDING = 4;

    int   cyc = 0;
    int   m_phase [NUM_CH];
    int   m_t_start [NUM_CH];
    int   m_t_fall [NUM_CH];
    int   m_p_cycles [NUM_CH];
    int   m_p_err [NUM_CH];
    logic [NUM_CH-1:0] m_prev_busy, m_viol;
    int   m_drop;
    int   m_ptr;
    rec_t m_q [$];

    int   pop_chans [$];
    int   last_cycles, last_err;

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) m_phase[c] = PH_IDLE;
        m_prev_busy = '0;
        m_viol      = '0;
        m_drop      = 0;
        m_ptr       = 0;
        m_q.delete();
    endtask

    task automatic model_step();
        bit pop, can_push;
        int g, ndrop, el;
        if (!reset) begin
            model_reset();
        end else begin
            pop      = (m_q.size() > 0) && rec_ready;
            can_push = (m_q.size() < FIFO_DEPTH) || pop;
            g = -1;
            if (can_push)
                for (int k = 0; k < NUM_CH; k++)
                    if (g < 0 && m_phase[(m_ptr + k) % NUM_CH] == PH_PENDING) g = (m_ptr + k) % NUM_CH;
            if (pop) void'(m_q.pop_front());
            if (g >= 0) begin
                m_q.push_back('{chan: g, cycles: m_p_cycles[g], err: m_p_err[g]});
                m_ptr = (g + 1) % NUM_CH;
            end
            ndrop = 0;
            for (int c = 0; c < NUM_CH; c++) begin
                el = cyc - m_t_start[c];
                if (el > CNT_MAX) el = CNT_MAX;
                case (m_phase[c])
                    PH_IDLE: begin
                        if (ch_irq[c] || (ch_busy[c] && !m_prev_busy[c])) m_viol[c] = 1'b1;
                        if (ch_start[c]) begin m_phase[c] = PH_WAIT_BUSY; m_t_start[c] = cyc; end
                    end
                    PH_WAIT_BUSY: begin
                        if (ch_start[c] || ch_irq[c]) m_viol[c] = 1'b1;
                        if (ch_busy[c]) m_phase[c] = PH_BUSY;
                        else if (el >= START_TO) begin
                            m_phase[c] = PH_PENDING; m_p_cycles[c] = el; m_p_err[c] = 1;
                        end
                    end
                    PH_BUSY: begin
                        if (ch_start[c]) m_viol[c] = 1'b1;
                        if (ch_irq[c]) begin
                            m_phase[c] = PH_PENDING; m_p_cycles[c] = el; m_p_err[c] = 0;
                        end else if (!ch_busy[c]) begin
                            m_phase[c] = PH_WAIT_IRQ; m_t_fall[c] = cyc;
                        end
                    end
                    PH_WAIT_IRQ: begin
                        if (ch_start[c]) m_viol[c] = 1'b1;
                        if (ch_irq[c]) begin
                            m_phase[c] = PH_PENDING; m_p_cycles[c] = el; m_p_err[c] = 0;
                        end else if (cyc - m_t_fall[c] >= IRQ_WIN) begin
                            m_phase[c] = PH_PENDING; m_p_cycles[c] = el; m_p_err[c] = 2;
                        end
                    end
                    default: begin
                        if (ch_start[c]) ndrop++;
                        if (c == g) m_phase[c] = PH_IDLE;
                    end
                endcase
            end
            m_drop      = (m_drop + ndrop > 255) ? 255 : m_drop + ndrop;
            m_prev_busy = ch_busy;
        end
        cyc++;
    endtask

    task automatic compare_all();
        logic [NUM_CH-1:0] exp_act;
        bit has = (m_q.size() > 0);
        for (int c = 0; c < NUM_CH; c++) exp_act[c] = (m_phase[c] != PH_IDLE);
        check("rec_valid", 32'(rec_valid), 32'(has));
        check("rec_chan", 32'(rec_chan), has ? 32'(m_q[0].chan) : 32'd0);
        check("rec_cycles", 32'(rec_cycles), has ? 32'(m_q[0].cycles) : 32'd0);
        check("rec_err", 32'(rec_err), has ? 32'(m_q[0].err) : 32'd0);
        check("fifo_level", 32'(fifo_level), 32'(m_q.size()));
        check("ch_active", 32'(ch_active), 32'(exp_act));
        check("proto_err", 32'(proto_err), 32'(m_viol));
        check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    endtask

    task automatic drive(input logic [NUM_CH-1:0] st, input logic [NUM_CH-1:0] bs,
                         input logic [NUM_CH-1:0] iq, input logic rdy, input logic rst_n);
        ch_start  = st;
        ch_busy   = bs;
        ch_irq    = iq;
        rec_ready = rdy;
        reset     = rst_n;
        if (rst_n && rec_valid === 1'b1 && rdy) begin
            pop_chans.push_back(int'(rec_chan));
            last_cycles = int'(rec_cycles);
            last_err    = int'(rec_err);
        end
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    localparam logic [NUM_CH-1:0] Z = '0;

    initial begin
        int exp_order [5] = '{0, 1, 2, 1, 0};
        int ready_pct;
        logic [NUM_CH-1:0] rbusy, rst_v, riq;
        model_reset();
        drive(Z, Z, Z, 1'b0, 1'b0);
        drive(Z, Z, Z, 1'b0, 1'b0);
        check("reset_valid", 32'(rec_valid), 32'd0);
        check("reset_level", 32'(fifo_level), 32'd0);
        check("reset_active", 32'(ch_active), 32'd0);

        // Normal ch0 task: start t0, busy t0+2..t0+10, irq t0+11.
        drive(3'b001, Z, Z, 1'b1, 1'b1);
        drive(Z, Z, Z, 1'b1, 1'b1);
        repeat (9) drive(Z, 3'b001, Z, 1'b1, 1'b1);
        drive(Z, Z, 3'b001, 1'b1, 1'b1);
        check("t1_valid_early", 32'(rec_valid), 32'd0);
        drive(Z, Z, Z, 1'b1, 1'b1);
        check("t1_valid", 32'(rec_valid), 32'd1);
        check("t1_chan", 32'(rec_chan), 32'd0);
        check("t1_cycles", 32'(rec_cycles), 32'd11);
        check("t1_err", 32'(rec_err), 32'd0);
        check("t1_active0", 32'(ch_active[0]), 32'd0);
        drive(Z, Z, Z, 1'b1, 1'b1);
        check("t1_valid_once", 32'(rec_valid), 32'd0);

        // ch1 start timeout.
        drive(3'b010, Z, Z, 1'b1, 1'b1);
        repeat (12) drive(Z, Z, Z, 1'b1, 1'b1);
        check("t2_chan", 32'(pop_chans[$]), 32'd1);
        check("t2_cycles", 32'(last_cycles), 32'd8);
        check("t2_err", 32'(last_err), 32'd1);
        check("t2_proto", 32'(proto_err), 32'd0);

        // ch2 missing irq, then a late irq while idle.
        drive(3'b100, Z, Z, 1'b1, 1'b1);
        repeat (2) drive(Z, 3'b100, Z, 1'b1, 1'b1);
        repeat (10) drive(Z, Z, Z, 1'b1, 1'b1);
        check("t3_chan", 32'(pop_chans[$]), 32'd2);
        check("t3_cycles", 32'(last_cycles), 32'd7);
        check("t3_err", 32'(last_err), 32'd2);
        drive(Z, Z, 3'b100, 1'b1, 1'b1);
        check("t3_proto2", 32'(proto_err[2]), 32'd1);

        // All channels complete together with the consumer stalled.
        pop_chans.delete();
        drive(3'b111, Z, Z, 1'b0, 1'b1);
        repeat (2) drive(Z, 3'b111, Z, 1'b0, 1'b1);
        drive(Z, Z, 3'b111, 1'b0, 1'b1);
        repeat (4) drive(Z, Z, Z, 1'b0, 1'b1);
        check("t4_level", 32'(fifo_level), 32'd3);
        check("t4_head", 32'(rec_chan), 32'd0);

        // Fill the FIFO, then ch0 completes and restarts while held.
        drive(3'b010, Z, Z, 1'b0, 1'b1);
        drive(Z, 3'b010, Z, 1'b0, 1'b1);
        drive(Z, Z, 3'b010, 1'b0, 1'b1);
        repeat (2) drive(Z, Z, Z, 1'b0, 1'b1);
        drive(3'b001, Z, Z, 1'b0, 1'b1);
        drive(Z, 3'b001, Z, 1'b0, 1'b1);
        drive(Z, Z, 3'b001, 1'b0, 1'b1);
        drive(Z, Z, Z, 1'b0, 1'b1);
        drive(3'b001, Z, Z, 1'b0, 1'b1);
        check("t5_drop", 32'(drop_cnt), 32'd1);
        check("t5_hold0", 32'(ch_active[0]), 32'd1);
        check("t5_full", 32'(fifo_level), 32'd4);
        drive(Z, Z, Z, 1'b1, 1'b1);
        check("t5_level", 32'(fifo_level), 32'd4);
        check("t5_idle0", 32'(ch_active[0]), 32'd0);
        repeat (6) drive(Z, Z, Z, 1'b1, 1'b1);
        check("t5_pops", 32'(pop_chans.size()), 32'd5);
        for (int i = 0; i < 5 && i < pop_chans.size(); i++)
            check("t5_order", 32'(pop_chans[i]), 32'(exp_order[i]));

        // Reset while ch1 runs and two records are queued.
        drive(3'b101, Z, Z, 1'b0, 1'b1);
        drive(Z, 3'b101, Z, 1'b0, 1'b1);
        drive(Z, Z, 3'b101, 1'b0, 1'b1);
        repeat (3) drive(Z, Z, Z, 1'b0, 1'b1);
        check("t6_queued", 32'(fifo_level), 32'd2);
        drive(3'b010, Z, Z, 1'b0, 1'b1);
        repeat (2) drive(Z, 3'b010, Z, 1'b0, 1'b1);
        drive(Z, Z, Z, 1'b0, 1'b0);
        check("t6_valid", 32'(rec_valid), 32'd0);
        check("t6_level", 32'(fifo_level), 32'd0);
        check("t6_active", 32'(ch_active), 32'd0);
        check("t6_proto", 32'(proto_err), 32'd0);
        check("t6_drop", 32'(drop_cnt), 32'd0);
        pop_chans.delete();
        drive(Z, Z, 3'b010, 1'b1, 1'b1);
        repeat (6) drive(Z, Z, Z, 1'b1, 1'b1);
        check("t6_no_record", 32'(pop_chans.size()), 32'd0);

        // Random traffic, including protocol violations, stalls and rare resets.
        rbusy = '0;
        ready_pct = 50;
        for (int n = 0; n < 3000; n++) begin
            if (n % 250 == 0) ready_pct = (n % 750 == 0) ? 10 : ((n % 500 == 0) ? 90 : 50);
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 5) == 0) rbusy[c] = ~rbusy[c];
                rst_v[c] = ($urandom_range(0, 9) == 0);
                riq[c]   = ($urandom_range(0, 11) == 0);
            end
            drive(rst_v, rbusy, riq, ($urandom_range(0, 99) < ready_pct),
                  ($urandom_range(0, 399) != 0));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
